mpeg_out_drain: RTL and testbench
=================================

Name: mpeg_out_drain

Overview:
- Downstream stage of the scrambler core's output FIFO.
- Pops bytes from the FIFO, which has a 1-cycle read latency: data is valid the cycle after the read strobe.
- Re-times the bytes onto a valid/ready byte stream through a small skid buffer.
- Counts output bytes, scans for MPEG start codes (00 00 01 xx) and flags end-of-stream completion against the upstream input byte count.

Parameters:
- DEPTH, 4, skid buffer entries (power of 2, >=3 for full throughput).
- CNT_W, 32, width of byte and start-code counters.

Ports:
- clk  in  1  single clock for the whole block.
- rst  in  1  synchronous reset, active-high.
- fifo_dout  in  8  output FIFO read data, valid 1 cycle after fifo_rd.
- fifo_empty  in  1  output FIFO empty flag.
- fifo_rd  out  1  FIFO pop strobe.
- in_total  in  CNT_W  bytes written into the core upstream; only sampled while stream_end=1.
- stream_end  in  1  upstream has written its last byte; level, stays high.
- m_data  out  8  output byte.
- m_valid  out  1  m_data valid.
- m_ready  in  1  consumer accepts when m_valid&&m_ready.
- m_last  out  1  qualifies the final byte of the stream.
- out_cnt  out  CNT_W  bytes accepted by the consumer.
- start_code_cnt  out  CNT_W  start codes seen on the accepted stream.
- seq_hdr_seen  out  1  sticky, start code 0xB3 seen.
- seq_end_seen  out  1  sticky, start code 0xB7 seen.
- done  out  1  sticky, stream fully drained.

Behaviour:
- Reset (sync, active-high, any cycle incl. mid-stream):
  - All outputs 0; skid occupancy, inflight flag, scanner history and counters cleared.
  - Bytes already popped but unaccepted are discarded.
- Read issue:
  - fifo_rd = ~fifo_empty && ~done && (occ + inflight) < DEPTH.
  - Computed from registered state only; no combinational path m_ready->fifo_rd.
  - inflight <= fifo_rd; when inflight=1, fifo_dout is written to the buffer tail that cycle.
- Skid buffer:
  - Circular, DEPTH entries; m_valid = (occ != 0); m_data = head entry.
  - Push and pop in the same cycle leave occ unchanged.
  - occ must never exceed DEPTH; the bench asserts this.
  - Latency: fifo_rd at cycle N -> m_valid at N+2 when the buffer was empty.
  - Steady throughput is 1 byte/cycle with m_ready held high.
- Accept (m_valid && m_ready):
  - out_cnt increments by 1, saturating at all-ones.
  - The scanner shifts the byte into a 3-byte history.
- Start code detection:
  - Triggers when the history is {00,00,01} at the time byte X is accepted.
  - Effect: start_code_cnt +1 (saturating); X==B3 sets seq_hdr_seen; X==B7 sets seq_end_seen.
  - Overlapping patterns count: 00 00 00 01 B3 gives one start code.
  - History resets only on rst.
- m_last = m_valid && stream_end && (out_cnt + 1 == in_total).
- done:
  - Set the cycle after a byte with m_last is accepted.
  - Also set when stream_end && in_total==0 && occ==0 && ~inflight.
  - Once done, fifo_rd is held 0 and counters freeze until rst.
- stream_end rising while bytes are still buffered: draining continues normally; m_last appears on the matching byte.
- fifo_empty asserted while inflight=1: the inflight byte is still captured.

Decomposition:
- Shared package mpeg_pkg:
  - START_PREFIX (24'h000001), SC_SEQ_HDR (8'hB3), SC_SEQ_END (8'hB7), byte_t typedef.
- One natural sub-module: mpeg_start_scan.
  - Inputs: accepted-byte strobe and data.
  - Outputs: start_code_cnt, seq_hdr_seen, seq_end_seen.
  - Reused on the scrambler's input side.
- The skid buffer and read control stay inline.

Test Plan:
- Basic latency: FIFO preloaded with 5 bytes, m_ready=1 -> fifo_rd at cycle 0, m_valid at cycle 2, bytes emerge in order, out_cnt=5.
- Backpressure: 16 bytes with m_ready toggled 1,0,0,1 -> no byte lost or duplicated, occ<=4, fifo_rd deasserts when occ+inflight==4.
- Start codes: stream 00 00 01 B3 11 00 00 00 01 B7 -> start_code_cnt=2, seq_hdr_seen=1, seq_end_seen=1.
- End handling: in_total=10, stream_end=1 after byte 6 is written -> m_last only on byte 10, done=1 the cycle after, fifo_rd stays 0 afterwards.
- Empty stream: stream_end=1, in_total=0, FIFO empty -> done=1 within 1 cycle, m_valid never asserted.
- Reset mid-stream: rst asserted for 1 cycle with occ=3 -> m_valid=0 and all counters 0 the next cycle; draining resumes correctly from new FIFO data.

Source files
------------

// File: rtl/mpeg_pkg.sv
// Shared MPEG constants and types for the scrambler output path and its
// start-code scanners.
package mpeg_pkg;
  typedef logic [7:0] byte_t;

  localparam logic [23:0] START_PREFIX = 24'h000001;
  localparam byte_t       SC_SEQ_HDR   = 8'hB3;
  localparam byte_t       SC_SEQ_END   = 8'hB7;
endpackage

// File: rtl/mpeg_start_scan.sv
// MPEG start-code scanner: counts 00 00 01 xx patterns on an accepted-byte
// strobe and keeps sticky flags for sequence header / sequence end codes.
module mpeg_start_scan
  import mpeg_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             acc_vld,
  input  byte_t            acc_data,
  output logic [CNT_W-1:0] start_code_cnt,
  output logic             seq_hdr_seen,
  output logic             seq_end_seen
);

  logic [23:0]      hist_q, hist_d;
  logic [1:0]       fill_q, fill_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hdr_q, hdr_d;
  logic             end_q, end_d;
  logic             is_sc;

  // fill_q keeps the reset-zeroed history from matching as a real 00 00 prefix
  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    cnt_d  = cnt_q;
    hdr_d  = hdr_q;
    end_d  = end_q;
    is_sc  = (fill_q == 2'd3) && (hist_q == START_PREFIX);
    if (acc_vld) begin
      hist_d = {hist_q[15:0], acc_data};
      fill_d = (fill_q == 2'd3) ? fill_q : fill_q + 2'd1;
      if (is_sc) begin
        cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
        if (acc_data == SC_SEQ_HDR) hdr_d = 1'b1;
        if (acc_data == SC_SEQ_END) end_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q <= '0;
      fill_q <= '0;
      cnt_q  <= '0;
      hdr_q  <= 1'b0;
      end_q  <= 1'b0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      cnt_q  <= cnt_d;
      hdr_q  <= hdr_d;
      end_q  <= end_d;
    end
  end

  assign start_code_cnt = cnt_q;
  assign seq_hdr_seen   = hdr_q;
  assign seq_end_seen   = end_q;

endmodule

// File: rtl/mpeg_out_drain.sv
// Drains the scrambler output FIFO (1-cycle read latency) into a skid buffer
// feeding a valid/ready byte stream; counts bytes and flags stream completion.
module mpeg_out_drain
  import mpeg_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       fifo_dout,
  input  logic             fifo_empty,
  output logic             fifo_rd,
  input  logic [CNT_W-1:0] in_total,
  input  logic             stream_end,
  output logic [7:0]       m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_last,
  output logic [CNT_W-1:0] out_cnt,
  output logic [CNT_W-1:0] start_code_cnt,
  output logic             seq_hdr_seen,
  output logic             seq_end_seen,
  output logic             done
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OW = AW + 1;

  byte_t            mem_q [DEPTH];
  byte_t            mem_d [DEPTH];
  logic [AW-1:0]    head_q, head_d, tail_q, tail_d;
  logic [OW-1:0]    occ_q, occ_d;
  logic             inflight_q, inflight_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic             done_q, done_d;

  logic [OW:0]      lvl;
  logic [CNT_W-1:0] cnt_inc;
  logic             push, pop, acc;

  // Read issue counts the inflight byte as occupied so the buffer never overflows
  // and m_ready never reaches fifo_rd combinationally.
  always_comb begin
    lvl     = {1'b0, occ_q} + (OW+1)'(inflight_q);
    fifo_rd = ~rst && ~fifo_empty && ~done_q && (lvl < (OW+1)'(DEPTH));
    m_valid = (occ_q != '0);
    m_data  = mem_q[head_q];
    cnt_inc = out_cnt_q + CNT_W'(1);
    m_last  = m_valid && stream_end && (cnt_inc == in_total);
    push    = inflight_q;
    pop     = m_valid && m_ready;
    acc     = pop && ~done_q;
  end

  always_comb begin
    mem_d      = mem_q;
    head_d     = head_q;
    tail_d     = tail_q;
    occ_d      = occ_q;
    inflight_d = fifo_rd;
    out_cnt_d  = out_cnt_q;
    done_d     = done_q;
    if (push) begin
      mem_d[tail_q] = fifo_dout;
      tail_d        = tail_q + AW'(1);
    end
    if (pop) head_d = head_q + AW'(1);
    case ({push, pop})
      2'b10:   occ_d = occ_q + OW'(1);
      2'b01:   occ_d = occ_q - OW'(1);
      default: occ_d = occ_q;
    endcase
    if (acc && ~(&out_cnt_q)) out_cnt_d = cnt_inc;
    if ((acc && m_last) ||
        (stream_end && (in_total == '0) && (occ_q == '0) && ~inflight_q))
      done_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      occ_q      <= '0;
      inflight_q <= 1'b0;
      out_cnt_q  <= '0;
      done_q     <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      out_cnt_q  <= out_cnt_d;
      done_q     <= done_d;
    end
  end

  mpeg_start_scan #(.CNT_W(CNT_W)) u_scan (
    .clk            (clk),
    .rst            (rst),
    .acc_vld        (acc),
    .acc_data       (m_data),
    .start_code_cnt (start_code_cnt),
    .seq_hdr_seen   (seq_hdr_seen),
    .seq_end_seen   (seq_end_seen)
  );

  assign out_cnt = out_cnt_q;
  assign done    = done_q;

endmodule

// File: tb/tb_mpeg_out_drain.sv
// Bench for mpeg_out_drain: FIFO model with 1-cycle read latency, byte
// scoreboard, start-code vector table and hand-written corner sequences.
module tb_mpeg_out_drain;
  localparam int DEPTH = 4;
  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [7:0]       fifo_dout = 8'h00;
  logic             fifo_empty;
  logic             fifo_rd;
  logic [CNT_W-1:0] in_total = '0;
  logic             stream_end = 1'b0;
  logic [7:0]       m_data;
  logic             m_valid;
  logic             m_ready = 1'b0;
  logic             m_last;
  logic [CNT_W-1:0] out_cnt;
  logic [CNT_W-1:0] start_code_cnt;
  logic             seq_hdr_seen;
  logic             seq_end_seen;
  logic             done;

  mpeg_out_drain #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
    .fifo_rd(fifo_rd), .in_total(in_total), .stream_end(stream_end),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .out_cnt(out_cnt), .start_code_cnt(start_code_cnt),
    .seq_hdr_seen(seq_hdr_seen), .seq_end_seen(seq_end_seen), .done(done)
  );

  always #5 clk = ~clk;

  // Upstream FIFO model: wr_ptr owned by the stimulus, rd_ptr by the pop process.
  logic [7:0] fifo_mem [1024];
  int         wr_ptr = 0;
  int         rd_ptr = 0;
  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (fifo_rd) begin
      fifo_dout <= fifo_mem[rd_ptr % 1024];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q [$];
  int         acc_cnt;
  int         last_cnt;
  bit         last_pending;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_raw(input logic [7:0] b);
    fifo_mem[wr_ptr % 1024] = b;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    push_raw(b);
    exp_q.push_back(b);
  endtask

  // Mid-cycle monitor: scoreboard, m_last model, done timing, occupancy bound.
  task automatic sample();
    @(negedge clk);
    if (dut.occ_q > DEPTH) chk("occ_bound", 32'(dut.occ_q), DEPTH);
    if (!rst) begin
      if (last_pending) begin
        chk("done_after_last", done, 1'b1);
        last_pending = 1'b0;
      end
      if (m_valid && !done) begin
        chk("m_last", m_last, stream_end && (acc_cnt + 1 == int'(in_total)));
        if (m_ready) begin
          if (exp_q.size() == 0) chk("unexpected_byte", m_data, 8'hxx);
          else chk("m_data", m_data, exp_q.pop_front());
          acc_cnt++;
          if (m_last) begin
            last_cnt++;
            last_pending = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic cycle();
    sample();
    advance();
  endtask

  // Leaves rst high after one clocked reset cycle; caller releases it.
  task automatic do_reset();
    rst        = 1'b1;
    stream_end = 1'b0;
    in_total   = '0;
    m_ready    = 1'b0;
    wr_ptr     = rd_ptr;
    exp_q.delete();
    acc_cnt      = 0;
    last_cnt     = 0;
    last_pending = 1'b0;
    cycle();
  endtask

  task automatic wait_done(input int maxc);
    for (int i = 0; i < maxc && !done; i++) cycle();
    if (!done) chk("done_timeout", done, 1'b1);
  endtask

  task automatic wait_drain(input int maxc);
    for (int i = 0; i < maxc && exp_q.size() != 0; i++) cycle();
    repeat (2) cycle();
    chk("drain_left", exp_q.size(), 0);
  endtask

  typedef struct {
    int              len;
    logic [0:9][7:0] b;
    int              sc;
    bit              hdr;
    bit              send;
  } sc_vec_t;

  sc_vec_t vecs [4];
  bit      ready_pat [4];

  initial begin
    vecs[0] = '{10, 80'h000001B3110000000_1B7, 2, 1'b1, 1'b1};
    vecs[1] = '{5,  80'h00000001B3_0000000000, 1, 1'b1, 1'b0};
    vecs[2] = '{5,  80'h0001B70000_0000000000, 0, 1'b0, 1'b0};
    vecs[3] = '{7,  80'h000001000001B7_000000, 2, 1'b0, 1'b1};
    ready_pat = '{1'b1, 1'b0, 1'b0, 1'b1};

    // Reset state
    do_reset();
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_out_cnt", out_cnt, 0);
    chk("rst_sc_cnt", start_code_cnt, 0);
    chk("rst_done", done, 1'b0);
    chk("rst_fifo_rd", fifo_rd, 1'b0);

    // Basic latency: 5 preloaded bytes, ready held high
    do_reset();
    for (int i = 0; i < 5; i++) push_byte(8'h10 + 8'(i));
    m_ready = 1'b1;
    rst = 1'b0;
    sample(); chk("lat_rd_c0", fifo_rd, 1'b1); chk("lat_vld_c0", m_valid, 1'b0); advance();
    sample(); chk("lat_vld_c1", m_valid, 1'b0); advance();
    sample(); chk("lat_vld_c2", m_valid, 1'b1); chk("lat_data_c2", m_data, 8'h10); advance();
    wait_drain(40);
    chk("lat_out_cnt", out_cnt, 5);

    // Backpressure: 16 bytes, ready 1,0,0,1
    do_reset();
    rst = 1'b0;
    for (int i = 0; i < 16; i++) push_byte(8'hA0 + 8'(i));
    for (int c = 0; c < 300 && exp_q.size() != 0; c++) begin
      m_ready = ready_pat[c % 4];
      sample();
      if (32'(dut.occ_q) + 32'(dut.inflight_q) == DEPTH) chk("bp_rd_full", fifo_rd, 1'b0);
      advance();
    end
    m_ready = 1'b1;
    wait_drain(20);
    chk("bp_out_cnt", out_cnt, 16);

    // Start-code vector table
    for (int v = 0; v < 4; v++) begin
      do_reset();
      in_total   = CNT_W'(vecs[v].len);
      stream_end = 1'b1;
      m_ready    = 1'b1;
      rst        = 1'b0;
      for (int i = 0; i < vecs[v].len; i++) push_byte(vecs[v].b[i]);
      wait_done(100);
      chk($sformatf("v%0d_sc_cnt", v), start_code_cnt, vecs[v].sc);
      chk($sformatf("v%0d_hdr", v), seq_hdr_seen, vecs[v].hdr);
      chk($sformatf("v%0d_end", v), seq_end_seen, vecs[v].send);
      chk($sformatf("v%0d_out_cnt", v), out_cnt, vecs[v].len);
      chk($sformatf("v%0d_left", v), exp_q.size(), 0);
    end

    // End handling: stream_end raised after byte 6, m_last only on byte 10
    do_reset();
    in_total = 10;
    m_ready  = 1'b1;
    rst      = 1'b0;
    for (int i = 0; i < 6; i++) push_byte(8'h60 + 8'(i));
    stream_end = 1'b1;
    repeat (3) cycle();
    for (int i = 6; i < 10; i++) push_byte(8'h60 + 8'(i));
    wait_done(100);
    cycle();
    chk("end_last_cnt", last_cnt, 1);
    push_raw(8'hEE);
    push_raw(8'hEF);
    repeat (6) begin
      sample(); chk("end_rd_held", fifo_rd, 1'b0); advance();
    end
    chk("end_out_cnt", out_cnt, 10);
    chk("end_done_sticky", done, 1'b1);

    // Empty stream
    do_reset();
    stream_end = 1'b1;
    in_total   = 0;
    m_ready    = 1'b1;
    rst        = 1'b0;
    cycle();
    sample(); chk("empty_done", done, 1'b1); advance();
    for (int i = 0; i < 5; i++) begin
      sample(); chk("empty_no_valid", m_valid, 1'b0); advance();
    end

    // Reset mid-stream with a partly filled buffer
    do_reset();
    m_ready = 1'b1;
    rst     = 1'b0;
    push_byte(8'h00); push_byte(8'h00); push_byte(8'h01); push_byte(8'hB3);
    for (int i = 0; i < 5; i++) push_byte(8'hC0 + 8'(i));
    for (int i = 0; i < 50 && acc_cnt < 4; i++) begin
      cycle();
      if (acc_cnt >= 4) m_ready = 1'b0;
    end
    m_ready = 1'b0;
    chk("mid_pre_hdr", seq_hdr_seen, 1'b1);
    chk("mid_pre_out_cnt", out_cnt, 4);
    begin
      bit hit = 1'b0;
      for (int i = 0; i < 20 && !hit; i++) begin
        sample();
        if (dut.occ_q == 3) hit = 1'b1;
        else advance();
      end
      chk("mid_occ3_reached", hit, 1'b1);
    end
    rst    = 1'b1;
    wr_ptr = rd_ptr;
    exp_q.delete();
    acc_cnt = 0;
    advance();
    rst = 1'b0;
    sample();
    chk("mid_m_valid", m_valid, 1'b0);
    chk("mid_out_cnt", out_cnt, 0);
    chk("mid_sc_cnt", start_code_cnt, 0);
    chk("mid_hdr", seq_hdr_seen, 1'b0);
    advance();
    m_ready = 1'b1;
    push_byte(8'h00); push_byte(8'h00); push_byte(8'h01); push_byte(8'hB7);
    wait_drain(40);
    chk("mid_post_out_cnt", out_cnt, 4);
    chk("mid_post_sc_cnt", start_code_cnt, 1);
    chk("mid_post_end", seq_end_seen, 1'b1);
    chk("mid_post_hdr", seq_hdr_seen, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
